// File: rtl/rx_iq_byte_packer.sv
// rtl/rx_iq_byte_packer.sv - I/Q sample FIFO and big-endian byte serialiser feeding the packet assembler
module rx_iq_byte_packer #(
  parameter int DEPTH     = 16,
  parameter int LEVEL_W   = 5,
  parameter int PAD_BYTES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_strobe,
  input  logic [23:0]        in_i,
  input  logic [23:0]        in_q,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               overflow,
  output logic [7:0]         drop_count,
  input  logic               clear_status
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FLEN = 6 + PAD_BYTES;
  localparam logic [2:0] LAST_IDX = 3'(FLEN - 1);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t        state;
  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [47:0]   hold;
  logic [2:0]    idx;

  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic frame_done;
  logic pop;
  logic push;
  logic drop;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LEVEL);
  assign accept     = out_valid && out_ready;
  assign frame_done = accept && (idx == LAST_IDX);
  // Pop either to start from idle or back-to-back when the last byte of a frame leaves.
  assign pop        = !fifo_empty && ((state == S_IDLE) || frame_done);
  // A pop in the same cycle frees a slot, so a full FIFO still takes the new sample.
  assign push       = in_strobe && (!fifo_full || pop);
  assign drop       = in_strobe && !push;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_i, in_q};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_W'(1);
        2'b01:   fifo_level <= fifo_level - LEVEL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      idx       <= '0;
      hold      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            hold      <= mem[rd_ptr];
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (frame_done) begin
            idx <= '0;
            if (pop) begin
              hold <= mem[rd_ptr];
            end else begin
              out_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end else if (accept) begin
            idx <= idx + 3'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

  // Clear and drop in the same cycle count that drop as the first one after the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_status) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (clear_status) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // Bytes past the 48-bit sample are the zero pad for the mic slot.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (idx)
        3'd0:    out_data = hold[47:40];
        3'd1:    out_data = hold[39:32];
        3'd2:    out_data = hold[31:24];
        3'd3:    out_data = hold[23:16];
        3'd4:    out_data = hold[15:8];
        3'd5:    out_data = hold[7:0];
        default: out_data = 8'h00;
      endcase
    end
  end

  assign out_last = out_valid && (idx == LAST_IDX);

endmodule
